// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP retransmission scheduler: the per-port
// state encoding and the width helper used to size counters and masks.
package tcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PEND  = 2'd2,
        ST_FAIL  = 2'd3
    } port_state_t;

    // Number of bits needed to hold the value 'value' (at least one).
    function automatic int bits_for(input int value);
        int n;
        n = 32'sd1;
        while ((32'sd1 <<< n) <= value) begin
            n = n + 32'sd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/tcp_rtx_timer.sv
// One port's retransmission state: FSM, timeout countdown and retry count.
// A send arms the countdown; an ACK or flush clears everything; expiry
// either requests a resend or, once retries are exhausted, latches failure.
module tcp_rtx_timer
    import tcp_pkg::*;
#(
    parameter int TO_CYCLES = 125000,
    parameter int MAX_RETRY = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic sent,
    input  logic ack,
    output logic pend,
    output logic failed,
    output logic enter_pend
);

    localparam int TW = bits_for(TO_CYCLES);
    localparam int RW = bits_for(MAX_RETRY);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TO_CYCLES - 32'sd1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(32'sd1);
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE  = RW'(32'sd1);
    localparam logic [RW-1:0] RETRY_ZERO = {RW{1'b0}};

    port_state_t     state_r;
    logic [TW-1:0]   timer_r;
    logic [RW-1:0]   retry_r;
    logic            expire_s;
    logic            can_retry_s;

    assign expire_s    = (state_r == ST_ARMED) && (timer_r == TIMER_ZERO);
    assign can_retry_s = (retry_r < RETRY_MAX);

    // A timeout only counts as a resend request if nothing of higher
    // priority (flush, ack, a fresh send) overrides it in the same cycle.
    assign enter_pend = expire_s && can_retry_s && !flush && !ack && !sent;
    assign pend       = (state_r == ST_PEND);
    assign failed     = (state_r == ST_FAIL);

    // Port FSM with priority flush > ack > sent > timer expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
            retry_r <= RETRY_ZERO;
        end else if (flush || ack) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
            retry_r <= RETRY_ZERO;
        end else if (sent) begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_ARMED;
                    timer_r <= TIMER_LOAD;
                    retry_r <= RETRY_ZERO;
                end
                ST_ARMED: begin
                    state_r <= ST_ARMED;
                    timer_r <= TIMER_LOAD;
                    retry_r <= retry_r;
                end
                ST_PEND: begin
                    state_r <= ST_ARMED;
                    timer_r <= TIMER_LOAD;
                    retry_r <= retry_r + RETRY_ONE;
                end
                ST_FAIL: begin
                    state_r <= ST_FAIL;
                    timer_r <= timer_r;
                    retry_r <= retry_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= TIMER_ZERO;
                    retry_r <= RETRY_ZERO;
                end
            endcase
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (expire_s) begin
                        state_r <= can_retry_s ? ST_PEND : ST_FAIL;
                        timer_r <= timer_r;
                    end else begin
                        state_r <= ST_ARMED;
                        timer_r <= timer_r - TIMER_ONE;
                    end
                    retry_r <= retry_r;
                end
                ST_IDLE, ST_PEND, ST_FAIL: begin
                    state_r <= state_r;
                    timer_r <= timer_r;
                    retry_r <= retry_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= TIMER_ZERO;
                    retry_r <= RETRY_ZERO;
                end
            endcase
        end
    end

endmodule

// File: rtl/tcp_rtx_scheduler.sv
// Retransmission scheduler: one timer per memory block, plus the logic that
// publishes a narrowed arbiter port mask (highest pending port + 1) whenever
// new resend requests appear, deferring the update while the arbiter is busy.
module tcp_rtx_scheduler
    import tcp_pkg::*;
#(
    parameter int DEVICE_NUM = 8,
    parameter int TO_CYCLES  = 125000,
    parameter int MAX_RETRY  = 7,
    localparam int SW = bits_for(DEVICE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEVICE_NUM-1:0] sent_i,
    input  logic [DEVICE_NUM-1:0] ack_i,
    input  logic                  flush_i,
    input  logic [DEVICE_NUM-1:0] sel_i,
    input  logic                  busy_i,
    output logic [DEVICE_NUM-1:0] repeat_o,
    output logic                  irq_repeat_o,
    output logic                  any_repeat_o,
    output logic [SW-1:0]         port_mask_o,
    output logic                  port_mask_chng_o,
    output logic [DEVICE_NUM-1:0] fail_o
);

    localparam logic [SW-1:0] MASK_ALL = SW'(DEVICE_NUM);

    logic [DEVICE_NUM-1:0] repeat_s;
    logic [DEVICE_NUM-1:0] fail_s;
    logic [DEVICE_NUM-1:0] enter_pend_s;
    logic                  any_repeat_s;
    logic                  enter_any_s;
    logic                  publish_s;
    logic [SW-1:0]         mask_cand_s;
    logic                  pend_new_r;
    logic [SW-1:0]         port_mask_r;
    logic                  port_mask_chng_r;

    for (genvar g = 0; g < DEVICE_NUM; g++) begin : g_port
        tcp_rtx_timer #(
            .TO_CYCLES (TO_CYCLES),
            .MAX_RETRY (MAX_RETRY)
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush_i),
            .sent       (sent_i[g]),
            .ack        (ack_i[g]),
            .pend       (repeat_s[g]),
            .failed     (fail_s[g]),
            .enter_pend (enter_pend_s[g])
        );
    end

    assign any_repeat_s = |repeat_s;
    assign enter_any_s  = |enter_pend_s;
    assign publish_s    = pend_new_r && !busy_i && any_repeat_s;

    // Highest-index pending port; the mask is that index plus one.
    always_comb begin
        mask_cand_s = MASK_ALL;
        for (int k = 0; k < DEVICE_NUM; k++) begin
            mask_cand_s = repeat_s[k] ? SW'(k + 32'sd1) : mask_cand_s;
        end
    end

    // Sticky new-pending flag, published mask and its one-cycle change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_new_r       <= 1'b0;
            port_mask_r      <= MASK_ALL;
            port_mask_chng_r <= 1'b0;
        end else if (flush_i) begin
            pend_new_r       <= 1'b0;
            port_mask_r      <= MASK_ALL;
            port_mask_chng_r <= 1'b0;
        end else begin
            // A new timeout re-arms the flag even in the cycle it is consumed;
            // it is dropped once published or once nothing is pending anymore.
            pend_new_r       <= enter_any_s || (pend_new_r && busy_i && any_repeat_s);
            port_mask_chng_r <= publish_s;
            if (!any_repeat_s) begin
                port_mask_r <= MASK_ALL;
            end else if (publish_s) begin
                port_mask_r <= mask_cand_s;
            end else begin
                port_mask_r <= port_mask_r;
            end
        end
    end

    assign repeat_o         = repeat_s;
    assign fail_o           = fail_s;
    assign any_repeat_o     = any_repeat_s;
    assign irq_repeat_o     = |(sel_i & repeat_s);
    assign port_mask_o      = port_mask_r;
    assign port_mask_chng_o = port_mask_chng_r;

endmodule

// File: tb/tb_tcp_rtx_scheduler.sv
// Scoreboard bench for tcp_rtx_scheduler (8 ports, 16-cycle timeout, 2 retries).
// The driver applies inputs just after each rising edge, asks a deadline-based
// reference model for the outputs of that cycle and queues them; a monitor on
// the falling edge pops and compares, and checks every mask strobe.
module tb_tcp_rtx_scheduler;

    localparam int DN = 8;
    localparam int TO = 16;
    localparam int MR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DN-1:0] sent_i = 8'h00;
    logic [DN-1:0] ack_i = 8'h00;
    logic          flush_i = 1'b0;
    logic [DN-1:0] sel_i = 8'h00;
    logic          busy_i = 1'b0;
    logic [DN-1:0] repeat_o;
    logic          irq_repeat_o;
    logic          any_repeat_o;
    logic [3:0]    port_mask_o;
    logic          port_mask_chng_o;
    logic [DN-1:0] fail_o;

    tcp_rtx_scheduler #(
        .DEVICE_NUM (DN),
        .TO_CYCLES  (TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sent_i           (sent_i),
        .ack_i            (ack_i),
        .flush_i          (flush_i),
        .sel_i            (sel_i),
        .busy_i           (busy_i),
        .repeat_o         (repeat_o),
        .irq_repeat_o     (irq_repeat_o),
        .any_repeat_o     (any_repeat_o),
        .port_mask_o      (port_mask_o),
        .port_mask_chng_o (port_mask_chng_o),
        .fail_o           (fail_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rep;
        logic [7:0] fl;
        logic       any;
        logic       irq;
        logic [3:0] mask;
        logic       chng;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_q[$];
    int   strobe_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Reference model: per-port flags, retry count and absolute timeout cycle.
    bit m_pend[DN];
    bit m_fail[DN];
    bit m_armed[DN];
    int m_ret[DN];
    int m_dl[DN];
    bit m_pnew;
    bit m_strobe;
    int m_mask;

    function automatic void model_reset();
        for (int k = 0; k < DN; k++) begin
            m_pend[k]  = 1'b0;
            m_fail[k]  = 1'b0;
            m_armed[k] = 1'b0;
            m_ret[k]   = 0;
            m_dl[k]    = 0;
        end
        m_pnew   = 1'b0;
        m_strobe = 1'b0;
        m_mask   = DN;
    endfunction

    function automatic void model_update(input logic [7:0] s, input logic [7:0] a,
                                         input logic f, input logic b);
        bit any_now = 1'b0;
        bit entered = 1'b0;
        bit pub;
        int hi = DN;
        for (int k = DN - 1; k >= 0; k--) begin
            if (m_pend[k]) begin
                if (!any_now) hi = k + 1;
                any_now = 1'b1;
            end
        end
        pub = m_pnew && !b && any_now;
        if (f) begin
            model_reset();
        end else begin
            for (int k = 0; k < DN; k++) begin
                if (a[k]) begin
                    m_armed[k] = 1'b0;
                    m_pend[k]  = 1'b0;
                    m_fail[k]  = 1'b0;
                    m_ret[k]   = 0;
                end else if (s[k]) begin
                    if (!m_fail[k]) begin
                        if (m_pend[k]) m_ret[k] = m_ret[k] + 1;
                        else if (!m_armed[k]) m_ret[k] = 0;
                        m_armed[k] = 1'b1;
                        m_pend[k]  = 1'b0;
                        m_dl[k]    = cyc + TO;
                    end
                end else if (m_armed[k] && cyc == m_dl[k]) begin
                    m_armed[k] = 1'b0;
                    if (m_ret[k] < MR) begin
                        m_pend[k] = 1'b1;
                        entered   = 1'b1;
                    end else begin
                        m_fail[k] = 1'b1;
                    end
                end
            end
            m_strobe = pub;
            if (!any_now) m_mask = DN;
            else if (pub) m_mask = hi;
            m_pnew = entered || (m_pnew && b && any_now);
        end
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected in that cycle.
    task automatic step(input logic [7:0] s, input logic [7:0] a, input logic f,
                        input logic b, input logic [7:0] sl, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        sent_i  = s;
        ack_i   = a;
        flush_i = f;
        busy_i  = b;
        sel_i   = sl;
        rst     = r;
        if (r) model_reset();
        for (int k = 0; k < DN; k++) begin
            e.rep[k] = m_pend[k];
            e.fl[k]  = m_fail[k];
        end
        e.any  = |e.rep;
        e.irq  = |(e.rep & sl);
        e.mask = 4'(m_mask);
        e.chng = m_strobe;
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        if (m_strobe) strobe_q.push_back(m_mask);
        if (!r) model_update(s, a, f, b);
        cyc = cyc + 1;
    endtask

    task automatic idle(input int n, input logic b, input logic [7:0] sl);
        for (int i = 0; i < n; i++) step(8'h00, 8'h00, 1'b0, b, sl, 1'b0);
    endtask

    exp_t mon_e;
    exp_t mon_a;
    int   mon_c;
    int   mon_m;

    // Monitor: per-cycle status check plus strobe-driven mask check.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_c = cyc_q.pop_front();
            mon_a = {repeat_o, fail_o, any_repeat_o, irq_repeat_o, port_mask_o, port_mask_chng_o};
            n_cmp = n_cmp + 1;
            if (mon_a !== mon_e) begin
                n_bad = n_bad + 1;
                $display("FAIL status cyc=%0d got rep=%h fl=%h any=%b irq=%b mask=%0d chng=%b want rep=%h fl=%h any=%b irq=%b mask=%0d chng=%b",
                         mon_c, mon_a.rep, mon_a.fl, mon_a.any, mon_a.irq, mon_a.mask, mon_a.chng,
                         mon_e.rep, mon_e.fl, mon_e.any, mon_e.irq, mon_e.mask, mon_e.chng);
            end
        end
        if (port_mask_chng_o === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (strobe_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL strobe_unexpected got mask=%0d want no strobe", port_mask_o);
            end else begin
                mon_m = strobe_q.pop_front();
                if (port_mask_o !== 4'(mon_m)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL strobe_mask got %0d want %0d", port_mask_o, mon_m);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [7:0] a;
        logic       f;
        logic       b;
        logic       r;
        logic [7:0] sl;
        model_reset();
        step(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(2, 1'b0, 8'h00);

        // Single timeout on port 3, published immediately.
        step(8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(20, 1'b0, 8'h08);
        step(8'h00, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0, 8'h00);

        // ACK before timeout, then ACK and send together.
        step(8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(9, 1'b0, 8'h00);
        step(8'h00, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(10, 1'b0, 8'h00);
        step(8'h20, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(20, 1'b0, 8'h00);

        // Ports 1 and 6 time out together while the arbiter is busy.
        step(8'h42, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(20, 1'b1, 8'h00);
        idle(5, 1'b0, 8'h00);
        step(8'h00, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0, 8'h00);

        // Port 2 exhausts its retries, ignores a further send, ACK clears.
        for (int i = 0; i < 3; i++) begin
            step(8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            idle(17, 1'b0, 8'h00);
        end
        step(8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(17, 1'b0, 8'h00);
        step(8'h00, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0, 8'h00);

        // Selected versus unselected pending port.
        step(8'h10, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0);
        idle(17, 1'b0, 8'h10);
        idle(2, 1'b0, 8'h01);
        step(8'h00, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);

        // Flush, then reset, with one port PEND and another ARMED.
        step(8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(5, 1'b0, 8'h00);
        step(8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(12, 1'b1, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(20, 1'b0, 8'h00);
        step(8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(5, 1'b0, 8'h00);
        step(8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(12, 1'b1, 8'h00);
        step(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(20, 1'b0, 8'h00);

        // Randomised traffic.
        b = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            s = 8'h00;
            a = 8'h00;
            for (int k = 0; k < DN; k++) begin
                s[k] = ($urandom_range(0, 39) == 0);
                a[k] = ($urandom_range(0, 119) == 0);
            end
            if ($urandom_range(0, 7) == 0) b = ~b;
            f  = ($urandom_range(0, 699) == 0);
            r  = ($urandom_range(0, 1499) == 0);
            sl = 8'h01 << $urandom_range(0, 7);
            step(s, a, f, b, sl, r);
        end

        @(negedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0 || strobe_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain got %0d status / %0d strobes outstanding want 0 / 0",
                     exp_q.size(), strobe_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
